uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver; the stage directly downstream of the team's UART transmitter.
- Consumes the 10-bit frame the transmitter puts on the line: start bit (0), 8 data bits LSB first, stop bit (1).
- Oversamples the line with a clock-count baud timer, checks framing and hands each byte to the parallel side over a valid/ready handshake.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal values are 4 and above.
- SYNC_STAGES, 2: flops in the rx input synchronizer; legal values are 2 and above.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available; held until accepted.
- ready  input  1  consumer accepts data when valid&&ready at posedge.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: frame completed while previous byte was unaccepted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - Synchronizer flops are set to 1.
  - State goes to IDLE; bit counter and baud counter are cleared.
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no partial byte is delivered.
- rxs is the synchronized rx, available SYNC_STAGES cycles after rx changes. All decisions below use rxs.
- IDLE:
  - Stays in IDLE while rxs=1.
  - rxs=0 moves to START and clears the baud counter.
- START:
  - At baud count CLKS_PER_BIT/2-1 (mid start bit), rxs is sampled.
  - Sample 1: glitch; return to IDLE with no flags raised.
  - Sample 0: move to DATA, clear the baud counter and set bit index to 0.
- DATA:
  - Every CLKS_PER_BIT cycles, rxs is sampled into shift register bit [index]; index then increments.
  - Bits are assembled LSB first.
  - After index 7 is sampled, move to STOP (or PARITY when the optional feature is enabled).
- STOP:
  - Sample rxs after CLKS_PER_BIT cycles (mid stop bit).
  - Sample 1: the byte is delivered (see handshake). Sample 0: frame_err pulses 1 cycle and the byte is discarded.
  - In both cases, go to IDLE on the next cycle. The receiver rearms mid stop bit, so back-to-back frames are tolerated.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each sample point.
- Handshake:
  - Delivery sets valid=1 and data=byte in the cycle after the stop sample.
  - valid&&ready at posedge clears valid on that edge.
  - Delivery while valid=1 and ready=0: pulse overrun and drop the new byte. data keeps the old byte and valid stays 1.
  - Delivery in the same cycle as valid&&ready: take the new byte with valid staying 1 and no overrun.
  - ready has no effect while valid=0.
- Latency: valid rises about SYNC_STAGES + 9.5×CLKS_PER_BIT + 1 cycles after the falling edge of the start bit on rx.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled mid-bit.
  - Parity is even: the sampled bit must equal ^byte.
  - Adds output parity_err (1 bit), which pulses 1 cycle at the stop-sample point on mismatch; the byte is discarded.
  - When both errors occur, frame_err and parity_err both pulse.
- Undefined: no PARITY state and no parity_err port. The frame is the 10-bit format only.

Test Plan:
- Bench uses CLKS_PER_BIT=8.
- Reset and idle: hold rst=0 for 3 cycles with rx=1, then release. All outputs are 0, and they stay 0 for 200 cycles of idle line.
- Single byte: send 0xA5 with ready=1. valid pulses 1 cycle with data=0xA5; frame_err=0 and overrun=0.
- Backpressure and overrun:
  - Send 0x3C then 0xC3 back-to-back with ready=0. First byte: valid=1, data=0x3C.
  - On the second frame's stop sample, overrun pulses and data stays 0x3C.
  - Raising ready clears valid the next cycle.
- Framing error: send 0x55 with stop bit forced 0. frame_err pulses once, valid stays 0, and the next valid frame 0x0F is received correctly.
- Glitch rejection: drive rx low for 2 cycles (shorter than CLKS_PER_BIT/2). Receiver returns to IDLE, busy drops, and no valid, frame_err or overrun is raised.
- Reset mid-frame: assert rst=0 during bit 4 of 0xFF. Outputs clear and valid is never raised. The following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, framing check, valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Handshake: a byte is transferred on any posedge where valid && ready.
  // valid then drops unless a new byte lands on that same edge.
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             idx_q;
  logic [7:0]             shift_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   rxs;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q;
  logic                   parity_err_q;
`endif

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (valid_q && ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF) begin
            if (rxs) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              cnt_q   <= '0;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_q     <= '0;
            par_bad_q <= (rxs != ^shift_q);
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rxs) frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_q <= 1'b1;
            if (rxs && !par_bad_q) begin
`else
            if (rxs) begin
`endif
              // A pending byte not taken on this edge blocks the new one.
              if (valid_q && !ready) begin
                overrun_q <= 1'b1;
              end else begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: idle, delivery, backpressure,
// framing error, glitch rejection and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor: sampled on the negedge, away from the active edge
  int         valid_cyc = 0;
  int         fe_cyc    = 0;
  int         ov_cyc    = 0;
  int         busy_cyc  = 0;
  int         nz_cyc    = 0;
  int         acc_cnt   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (valid)     valid_cyc++;
      if (frame_err) fe_cyc++;
      if (overrun)   ov_cyc++;
      if (busy)      busy_cyc++;
      if (valid || frame_err || overrun || busy || data != 8'h00) nz_cyc++;
      if (valid && ready) begin
        acc_cnt++;
        got_q.push_back(data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks: inputs change 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_bit);
    rx = 1'b1;
  endtask

  int v0, f0, o0, b0, a0, n0;

  initial begin
    rst   = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // reset and idle
    @(negedge clk);
    check("rst_data",  {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_fe",    {31'd0, frame_err}, 32'd0);
    check("rst_ov",    {31'd0, overrun}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    n0 = nz_cyc;
    repeat (200) tick();
    check("idle_quiet", nz_cyc - n0, 32'd0);

    // single byte with ready high
    ready = 1'b1;
    v0 = valid_cyc; f0 = fe_cyc; o0 = ov_cyc; a0 = acc_cnt;
    send_byte(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    repeat (20) tick();
    check("a5_valid_cyc", valid_cyc - v0, 32'd1);
    check("a5_accepts",   acc_cnt - a0, 32'd1);
    check("a5_fe",        fe_cyc - f0, 32'd0);
    check("a5_ov",        ov_cyc - o0, 32'd0);

    // backpressure and overrun
    ready = 1'b0;
    o0 = ov_cyc; a0 = acc_cnt;
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    check("bp_valid1", {31'd0, valid}, 32'd1);
    check("bp_data1",  {24'd0, data}, 32'h3C);
    tick();
    send_byte(8'hC3, 1'b1);
    @(negedge clk);
    check("bp_ov_pulse", ov_cyc - o0, 32'd1);
    check("bp_data_kept", {24'd0, data}, 32'h3C);
    check("bp_valid_held", {31'd0, valid}, 32'd1);
    tick();
    ready = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    @(negedge clk);
    check("bp_valid_clr", {31'd0, valid}, 32'd0);
    check("bp_accepts", acc_cnt - a0, 32'd1);
    tick();

    // framing error then a good frame
    v0 = valid_cyc; f0 = fe_cyc; a0 = acc_cnt;
    send_byte(8'h55, 1'b0);
    repeat (20) tick();
    check("fe_pulse", fe_cyc - f0, 32'd1);
    check("fe_no_valid", valid_cyc - v0, 32'd0);
    send_byte(8'h0F, 1'b1);
    exp_q.push_back(8'h0F);
    repeat (20) tick();
    check("fe_recover", acc_cnt - a0, 32'd1);

    // glitch rejection
    v0 = valid_cyc; f0 = fe_cyc; o0 = ov_cyc; b0 = busy_cyc;
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("gl_busy_seen", {31'd0, (busy_cyc - b0) > 0}, 32'd1);
    check("gl_busy_drop", {31'd0, busy}, 32'd0);
    check("gl_quiet", (valid_cyc - v0) + (fe_cyc - f0) + (ov_cyc - o0), 32'd0);
    tick();

    // reset during bit 4 of 0xFF
    v0 = valid_cyc; a0 = acc_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    rx = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_valid", {31'd0, valid}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("mr_no_valid", valid_cyc - v0, 32'd0);
    send_byte(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    repeat (20) tick();
    check("mr_recover", acc_cnt - a0, 32'd1);

    // scoreboard
    check("sb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("sb_byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
